hub75_frame_ctrl: RTL and testbench

HUB75_FRAME_CTRL -- requirements
Module: hub75_frame_ctrl

---
 rtl/hub75_frame_ctrl.sv | 93 +++++++++
 tb/tb_hub75_frame_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hub75_frame_ctrl.sv
// hub75_frame_ctrl: HUB75 frame pacing FSM with tear-free double-buffer swap.
// Optional overrun counter is built only when HUB75_FRAME_OVERRUN_EN is defined.
module hub75_frame_ctrl #(
    parameter int PERIOD_W = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                scan_go,
    input  logic                scan_rdy,
    input  logic                swap_req,
    output logic                swap_ack,
    output logic                fb_sel,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [7:0]          overrun_cnt,
    output logic                busy
);
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_SWAP, ST_GO, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] timer_q, timer_d, load_val;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fb_q, fb_d, pend_q, pend_d, apply;

    // next-state logic; WAIT only launches once the period has elapsed and the scanner is idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = enable ? ST_WAIT : ST_IDLE;
            ST_WAIT: state_d = !enable ? ST_IDLE : (timer_q == '0 && scan_rdy) ? ST_SWAP : ST_WAIT;
            ST_SWAP: state_d = ST_GO;
            ST_GO:   state_d = ST_RUN;
            ST_RUN:  state_d = scan_rdy ? ST_WAIT : ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // timer holds cycles left before WAIT may launch; the fixed WAIT/SWAP/GO cycles are
    // subtracted from the load so GO-to-GO spacing equals cfg_period for a fast scanner
    always_comb begin
        load_val = (cfg_period > PERIOD_W'(3)) ? cfg_period - PERIOD_W'(3) : '0;
        timer_d  = (state_q == ST_GO) ? load_val : (timer_q == '0) ? '0 : timer_q - PERIOD_W'(1);
        cnt_d    = (state_q == ST_GO) ? cnt_q + CNT_W'(1) : cnt_q;
        apply    = (state_q == ST_SWAP) && pend_q;
        fb_d     = fb_q ^ apply;
        pend_d   = (pend_q & ~apply) | swap_req;
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            fb_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            fb_q    <= fb_d;
            pend_q  <= pend_d;
        end
    end

    // fb_sel and swap_ack both move inside the SWAP cycle itself, never during a scan
    assign scan_go   = (state_q == ST_GO);
    assign swap_ack  = apply;
    assign fb_sel    = fb_d;
    assign frame_cnt = cnt_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef HUB75_FRAME_OVERRUN_EN
    logic [7:0] ovr_q, ovr_d;

    // count a frame once when its timer expires while the scanner is still busy
    always_comb begin
        ovr_d = (state_q == ST_RUN && timer_q == PERIOD_W'(1) && !scan_rdy && ovr_q != 8'hff) ? ovr_q + 8'd1 : ovr_q;
    end

    // overrun counter register
    always_ff @(posedge clk) begin
        if (!rst_n) ovr_q <= '0;
        else        ovr_q <= ovr_d;
    end

    assign overrun_cnt = ovr_q;
`else
    assign overrun_cnt = '0;
`endif
endmodule

// File: tb/tb_hub75_frame_ctrl.sv
// tb_hub75_frame_ctrl: directed self-checking bench for hub75_frame_ctrl with a simple scanner model.
module tb_hub75_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, enable, swap_req;
    logic [15:0] cfg_period;
    logic        scan_go, swap_ack, fb_sel, busy;
    logic        scan_rdy = 1'b1;
    logic [15:0] frame_cnt;
    logic [7:0]  overrun_cnt;
    int          checks = 0, failures = 0;
    int          busy_len = 10, bcnt = 0;

    hub75_frame_ctrl #(.PERIOD_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_period(cfg_period),
        .scan_go(scan_go), .scan_rdy(scan_rdy), .swap_req(swap_req), .swap_ack(swap_ack),
        .fb_sel(fb_sel), .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // scanner: drops ready the cycle after scan_go, raises it busy_len cycles later
    always @(posedge clk) begin
        if (scan_go) begin
            scan_rdy <= 1'b0;
            bcnt     <= busy_len;
        end else if (bcnt > 1) bcnt <= bcnt - 1;
        else if (bcnt == 1) begin
            bcnt     <= 0;
            scan_rdy <= 1'b1;
        end
    end

    task automatic wait_go(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scan_go && n < budget);
        if (!scan_go) n = -1;
    endtask

    task automatic test_reset;
        rst_n = 0; enable = 0; swap_req = 0; cfg_period = 0;
        repeat (3) @(negedge clk);
        checks++; if (scan_go !== 1'b0) begin failures++; $display("FAIL reset_scan_go got=%b exp=0", scan_go); end
        checks++; if (swap_ack !== 1'b0) begin failures++; $display("FAIL reset_swap_ack got=%b exp=0", swap_ack); end
        checks++; if (fb_sel !== 1'b0) begin failures++; $display("FAIL reset_fb_sel got=%b exp=0", fb_sel); end
        checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
        checks++; if (overrun_cnt !== 8'd0) begin failures++; $display("FAIL reset_overrun got=%0d exp=0", overrun_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1;
    endtask

    task automatic test_period100;
        int n;
        cfg_period = 100; busy_len = 40; enable = 1;
        wait_go(10, n);
        checks++; if (n !== 3) begin failures++; $display("FAIL first_go_latency got=%0d exp=3", n); end
        checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL first_frame_cnt got=%0d exp=0", frame_cnt); end
        for (int k = 1; k <= 3; k++) begin
            wait_go(110, n);
            checks++; if (n !== 100) begin failures++; $display("FAIL period100_interval%0d got=%0d exp=100", k, n); end
            checks++; if (frame_cnt !== 16'(k)) begin failures++; $display("FAIL period100_cnt%0d got=%0d exp=%0d", k, frame_cnt, k); end
        end
    endtask

    task automatic test_period0;
        int n;
        cfg_period = 0; busy_len = 10;
        wait_go(110, n);
        for (int k = 1; k <= 2; k++) begin
            wait_go(30, n);
            checks++; if (n !== 14) begin failures++; $display("FAIL period0_interval%0d got=%0d exp=14", k, n); end
        end
        checks++; if (overrun_cnt !== 8'd0) begin failures++; $display("FAIL period0_overrun got=%0d exp=0", overrun_cnt); end
    endtask

    task automatic test_swap_in_swap;
        int n;
        @(negedge clk); swap_req = 1;
        @(negedge clk); swap_req = 0;
        n = 0;
        while (!swap_ack && n < 20) begin @(negedge clk); n++; end
        checks++; if (swap_ack !== 1'b1) begin failures++; $display("FAIL sis_first_ack got=%b exp=1", swap_ack); end
        checks++; if (fb_sel !== 1'b1) begin failures++; $display("FAIL sis_first_fb got=%b exp=1", fb_sel); end
        swap_req = 1;
        @(negedge clk); swap_req = 0;
        checks++; if (scan_go !== 1'b1) begin failures++; $display("FAIL sis_go_after_swap got=%b exp=1", scan_go); end
        n = 0;
        do begin @(negedge clk); n++; end while (!swap_ack && n < 20);
        checks++; if (n !== 13) begin failures++; $display("FAIL sis_second_ack_delay got=%0d exp=13", n); end
        checks++; if (fb_sel !== 1'b0) begin failures++; $display("FAIL sis_second_fb got=%b exp=0", fb_sel); end
    endtask

    task automatic test_swap_merge;
        int n, acks, bad;
        wait_go(20, n);
        bad = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            swap_req = (i % 2 == 1);
            if (fb_sel !== 1'b0 || swap_ack !== 1'b0) bad++;
        end
        swap_req = 0;
        acks = 0; n = 0;
        do begin
            @(negedge clk); n++;
            if (swap_ack) begin acks++; if (fb_sel !== 1'b1) bad++; end
            else if (!scan_go && fb_sel !== 1'b0) bad++;
        end while (!scan_go && n < 20);
        checks++; if (acks !== 1) begin failures++; $display("FAIL merge_ack_count got=%0d exp=1", acks); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL merge_fb_stable got=%0d bad cycles exp=0", bad); end
        checks++; if (scan_go !== 1'b1 || fb_sel !== 1'b1) begin failures++; $display("FAIL merge_fb_at_go got go=%b fb=%b exp go=1 fb=1", scan_go, fb_sel); end
        acks = 0; bad = 0; n = 0;
        do begin
            @(negedge clk); n++;
            if (swap_ack) acks++;
            if (fb_sel !== 1'b1) bad++;
        end while (!scan_go && n < 20);
        checks++; if (acks !== 0 || bad !== 0) begin failures++; $display("FAIL merge_next_frame got acks=%0d bad=%0d exp 0 0", acks, bad); end
    endtask

    task automatic test_overrun;
        int n, bad, exp5, exp300;
`ifdef HUB75_FRAME_OVERRUN_EN
        exp5 = 5; exp300 = 255;
`else
        exp5 = 0; exp300 = 0;
`endif
        cfg_period = 20; busy_len = 50;
        wait_go(60, n);
        bad = 0;
        for (int k = 1; k <= 5; k++) begin wait_go(60, n); if (n !== 54) bad++; end
        checks++; if (bad !== 0) begin failures++; $display("FAIL overrun_interval got=%0d bad intervals exp=0", bad); end
        checks++; if (overrun_cnt !== 8'(exp5)) begin failures++; $display("FAIL overrun_5 got=%0d exp=%0d", overrun_cnt, exp5); end
        for (int k = 6; k <= 300; k++) begin wait_go(60, n); if (n !== 54) bad++; end
        checks++; if (bad !== 0) begin failures++; $display("FAIL overrun_interval_long got=%0d bad intervals exp=0", bad); end
        checks++; if (overrun_cnt !== 8'(exp300)) begin failures++; $display("FAIL overrun_300 got=%0d exp=%0d", overrun_cnt, exp300); end
    endtask

    task automatic test_enable_off;
        int n, gos, bad;
        cfg_period = 0; busy_len = 10;
        wait_go(60, n);
        @(negedge clk); enable = 0;
        n = 0;
        while (!scan_rdy && n < 30) begin @(negedge clk); n++; end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL off_busy_r0 got=%b exp=1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL off_busy_r1 got=%b exp=1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL off_busy_r2 got=%b exp=0", busy); end
        gos = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            swap_req = (i == 3);
            if (scan_go) gos++;
            if (busy || swap_ack || fb_sel !== 1'b1) bad++;
        end
        swap_req = 0;
        checks++; if (gos !== 0) begin failures++; $display("FAIL off_no_go got=%0d exp=0", gos); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL off_idle_stable got=%0d bad cycles exp=0", bad); end
        enable = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!swap_ack && n < 10);
        checks++; if (n !== 2 || fb_sel !== 1'b0) begin failures++; $display("FAIL idle_pending_swap got delay=%0d fb=%b exp delay=2 fb=0", n, fb_sel); end
    endtask

    task automatic test_reset_mid_run;
        int n, early, acks;
        wait_go(20, n);
        @(negedge clk); swap_req = 1;
        @(negedge clk); swap_req = 0;
        wait_go(20, n);
        @(negedge clk); swap_req = 1;
        @(negedge clk); swap_req = 0;
        checks++; if (fb_sel !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL pre_reset_state got fb=%b busy=%b exp 1 1", fb_sel, busy); end
        @(negedge clk); rst_n = 0;
        @(negedge clk);
        checks++; if ({scan_go, swap_ack, fb_sel, busy} !== 4'b0000) begin failures++; $display("FAIL midrun_reset_bits got go/ack/fb/busy=%b exp=0000", {scan_go, swap_ack, fb_sel, busy}); end
        checks++; if (frame_cnt !== 16'd0 || overrun_cnt !== 8'd0) begin failures++; $display("FAIL midrun_reset_cnts got frame=%0d ovr=%0d exp 0 0", frame_cnt, overrun_cnt); end
        rst_n = 1;
        early = 0; acks = 0; n = 0;
        while (!scan_rdy && n < 30) begin
            @(negedge clk); n++;
            if (scan_go) early++;
        end
        checks++; if (early !== 0) begin failures++; $display("FAIL go_while_not_rdy got=%0d exp=0", early); end
        n = 0;
        do begin @(negedge clk); n++; if (swap_ack) acks++; end while (!scan_go && n < 10);
        checks++; if (n !== 2) begin failures++; $display("FAIL post_reset_go_delay got=%0d exp=2", n); end
        checks++; if (acks !== 0 || fb_sel !== 1'b0) begin failures++; $display("FAIL post_reset_no_swap got acks=%0d fb=%b exp 0 0", acks, fb_sel); end
    endtask

    initial begin
        test_reset;
        test_period100;
        test_period0;
        test_swap_in_swap;
        test_swap_merge;
        test_overrun;
        test_enable_off;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
